jk_to_sr_ff_bank: RTL

- Bank of WIDTH SR flip-flops. Each bit is built on an internal JK flip-flop core through S/R-to-J/K conversion logic.
- This is the opposite conversion to our JK-from-SR cell. The risk here is that a JK core toggles on J=K=1, which an SR flip-flop must never do.
- Adds illegal-input (S=R=1) detection, per-bit sticky error flags and a saturating event counter, so control paths driving SR-style latches can be monitored.

---
 rtl/jk_to_sr_ff_bank.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/jk_to_sr_ff_bank.sv
// -----------------------------------------------------------------------------
// jk_to_sr_ff_bank
//
// Bank of WIDTH SR flip-flops. Each bit is a JK flip-flop core driven through
// S/R-to-J/K conversion logic. The conversion guarantees J and K are never high
// together, so the core has no reachable toggle path. Simultaneous S=R=1 is
// flagged, recorded in per-bit sticky flags and counted in a saturating
// counter so that control paths driving SR-style latches can be monitored.
//
// Parameters
//   WIDTH          number of SR bits
//   ILLEGAL_POLICY next-state on S=R=1: 0 hold, 1 set-dominant,
//                  2 reset-dominant; any other value behaves as 0
//   ERR_CNT_W      width of the illegal-event counter
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (overrides en and err_clr)
//   en             clock enable for Q, detection and counting
//   S, R           per-bit set / reset requests
//   err_clr        synchronous clear of err_sticky, err_count, err_count_sat
//   Q, Qn          registered state and its complement
//   illegal        one-cycle per-bit flag of S=R=1 at the previous enabled edge
//   illegal_any    OR of illegal
//   err_sticky     per-bit sticky record of illegal events
//   err_count      saturating count of enabled cycles with any illegal bit
//   err_count_sat  high while err_count is at its maximum
// -----------------------------------------------------------------------------

// Single JK flip-flop core. J=K=1 resolves to reset rather than toggle; the
// surrounding conversion logic never produces that combination anyway.
module jk_ff_core (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            unique case ({j_i, k_i})
                2'b10:   q_d = 1'b1;
                2'b01:   q_d = 1'b0;
                2'b11:   q_d = 1'b0;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

module jk_to_sr_ff_bank #(
    parameter int WIDTH          = 4,
    parameter int ILLEGAL_POLICY = 0,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     S,
    input  logic [WIDTH-1:0]     R,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     Qn,
    output logic [WIDTH-1:0]     illegal,
    output logic                 illegal_any,
    output logic [WIDTH-1:0]     err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_count_sat
);

    // Unsupported policy values collapse to hold.
    localparam int POLICY = ((ILLEGAL_POLICY == 1) || (ILLEGAL_POLICY == 2)) ?
                            ILLEGAL_POLICY : 0;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // S/R to J/K conversion. Each policy keeps J and K mutually exclusive:
    // the dominant input passes through, the other is masked by it.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] j_w;
    logic [WIDTH-1:0] k_w;
    logic [WIDTH-1:0] sr_both_w;

    assign sr_both_w = S & R;

    always_comb begin
        j_w = S & ~R;
        k_w = R & ~S;
        if (POLICY == 1) begin
            j_w = S;
        end else if (POLICY == 2) begin
            k_w = R;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit JK cores
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_w;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_ff_core u_core (
            .clk  (clk),
            .rst  (rst),
            .en_i (en),
            .j_i  (j_w[gi]),
            .k_i  (k_w[gi]),
            .q_o  (q_w[gi])
        );
    end

    assign Q  = q_w;
    assign Qn = ~q_w;

    // ------------------------------------------------------------------
    // Illegal-input monitoring
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     illegal_q,  illegal_d;
    logic [WIDTH-1:0]     sticky_q,   sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q,      cnt_d;
    logic                 sat_q,      sat_d;
    logic [ERR_CNT_W-1:0] cnt_base;
    logic [WIDTH-1:0]     sticky_base;
    logic                 event_w;

    assign event_w = en && (|sr_both_w);

    always_comb begin
        // err_clr wipes the old state first, so an event at the same edge
        // lands on top of a cleared record.
        cnt_base    = err_clr ? '0 : cnt_q;
        sticky_base = err_clr ? '0 : sticky_q;

        illegal_d = '0;
        sticky_d  = sticky_base;
        cnt_d     = cnt_base;

        if (en) begin
            illegal_d = sr_both_w;
            sticky_d  = sticky_base | sr_both_w;
        end

        if (event_w) begin
            if (cnt_base == CNT_MAX) begin
                cnt_d = CNT_MAX;
            end else begin
                cnt_d = cnt_base + CNT_ONE;
            end
        end

        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= '0;
            sticky_q  <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    assign illegal       = illegal_q;
    assign illegal_any   = |illegal_q;
    assign err_sticky    = sticky_q;
    assign err_count     = cnt_q;
    assign err_count_sat = sat_q;

endmodule
